// File: rtl/breakout_field.sv
// Breakout brick field: per-brick hit points, sequential ball collision
// scan (one brick per cycle), scoring and combinational brick rendering.
module breakout_field #(
  parameter int ROWS       = 6,
  parameter int COLS       = 8,
  parameter int BRICK_W    = 35,
  parameter int BRICK_H    = 20,
  parameter int REGION_X_L = 40,
  parameter int REGION_Y_T = 30,
  parameter int BALL_SIZE  = 8,
  parameter int HP_W       = 2,
  parameter int INIT_HP    = 1,
  parameter int PTS_KILL   = 10,
  localparam int N   = ROWS * COLS,
  localparam int BLW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           gra_still,
  input  logic           refr_tick,
  input  logic [9:0]     ball_x_l,
  input  logic [9:0]     ball_y_t,
  input  logic [9:0]     pix_x,
  input  logic [9:0]     pix_y,
  output logic           brick_on,
  output logic [11:0]    brick_rgb,
  output logic           hit,
  output logic           hit_vert,
  output logic           new_dir,
  output logic [15:0]    score,
  output logic [BLW-1:0] bricks_left,
  output logic           cleared,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [9:0]      bx, by;
  logic            hv, nd;
  logic [HP_W-1:0] hp [N];

  logic [11:0] left, right, top, bot;
  logic [11:0] xl, xr, yt, yb;
  logic        live, overlap, cond_v, cond_h;
  logic        scan_hit, last, kill;
  logic [16:0] sum;

  always_comb begin
    left    = 12'(REGION_X_L + int'(col) * BRICK_W);
    right   = left + 12'(BRICK_W - 1);
    top     = 12'(REGION_Y_T + int'(row) * BRICK_H);
    bot     = top + 12'(BRICK_H - 1);
    xl      = {2'b00, bx};
    yt      = {2'b00, by};
    xr      = xl + 12'(BALL_SIZE - 1);
    yb      = yt + 12'(BALL_SIZE - 1);
    live    = hp[idx] != '0;
    overlap = live && left <= xr && xl <= right
              && top <= yb && yt <= bot;
    cond_v  = left < xr && xl < right;
    cond_h  = top < yb && yt < bot;
    scan_hit = (state == SCAN) && overlap
               && (cond_v || cond_h);
    last    = idx == IW'(N - 1);
    kill    = hp[idx] == HP_W'(1);
    sum     = {1'b0, score}
              + (kill ? 17'(PTS_KILL) : 17'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (refr_tick) state_nxt = SCAN;
      SCAN: begin
        if (scan_hit)  state_nxt = RESOLVE;
        else if (last) state_nxt = IDLE;
      end
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (gra_still) state_nxt = IDLE;
  end

  always_comb begin
    hit      = (state == RESOLVE) && !gra_still && !reset;
    hit_vert = hv;
    new_dir  = nd;
    busy     = state != IDLE;
    cleared  = bricks_left == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      col         <= '0;
      row         <= '0;
      bx          <= '0;
      by          <= '0;
      hv          <= 1'b0;
      nd          <= 1'b0;
      bricks_left <= '0;
      score       <= '0;
      for (int i = 0; i < N; i++) hp[i] <= '0;
    end else if (gra_still) begin
      bricks_left <= BLW'(N);
      for (int i = 0; i < N; i++) hp[i] <= HP_W'(INIT_HP);
    end else begin
      unique case (state)
        IDLE: begin
          if (refr_tick) begin
            bx  <= ball_x_l;
            by  <= ball_y_t;
            idx <= '0;
            col <= '0;
            row <= '0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            hv <= cond_v;
            nd <= cond_v ? !(yt < top) : !(xl < left);
          end else if (!last) begin
            idx <= idx + 1'b1;
            if (col == CW'(COLS - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        RESOLVE: begin
          hp[idx] <= hp[idx] - 1'b1;
          if (kill) bricks_left <= bricks_left - 1'b1;
          score <= sum[16] ? 16'hFFFF : sum[15:0];
        end
        default: ;
      endcase
    end
  end

  // Render: locate the cell under the pixel; mortar is the last px row/col.
  int          pc, pr;
  logic        in_c, in_r;
  logic [HP_W-1:0] hpk;

  always_comb begin
    pc   = 0;
    pr   = 0;
    in_c = 1'b0;
    in_r = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(pix_x) >= REGION_X_L + c * BRICK_W &&
          int'(pix_x) <= REGION_X_L + c * BRICK_W + BRICK_W - 2) begin
        in_c = 1'b1;
        pc   = c;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (int'(pix_y) >= REGION_Y_T + r * BRICK_H &&
          int'(pix_y) <= REGION_Y_T + r * BRICK_H + BRICK_H - 2) begin
        in_r = 1'b1;
        pr   = r;
      end
    end
    hpk      = hp[pr * COLS + pc];
    brick_on = in_c && in_r && hpk != '0;
    if (!brick_on)              brick_rgb = 12'h000;
    else if (hpk == HP_W'(1))   brick_rgb = 12'hf00;
    else if (hpk == HP_W'(2))   brick_rgb = 12'hf80;
    else                        brick_rgb = 12'h888;
  end

endmodule

// File: tb/tb_breakout_field.sv
// Directed bench for breakout_field with a hit scoreboard; a second
// instance with two hit points per brick shares the stimulus.
module tb_breakout_field;

  logic       clk = 1'b0;
  logic       reset, gra_still, refr_tick;
  logic [9:0] ball_x_l, ball_y_t, pix_x, pix_y;

  logic        on1, hit1, hv1, nd1, clr1, busy1;
  logic [11:0] rgb1;
  logic [15:0] score1;
  logic [5:0]  bl1;

  logic        on2, hit2, hv2, nd2, clr2, busy2;
  logic [11:0] rgb2;
  logic [15:0] score2;
  logic [5:0]  bl2;

  breakout_field u1 (
    .clk(clk), .reset(reset), .gra_still(gra_still),
    .refr_tick(refr_tick), .ball_x_l(ball_x_l), .ball_y_t(ball_y_t),
    .pix_x(pix_x), .pix_y(pix_y), .brick_on(on1), .brick_rgb(rgb1),
    .hit(hit1), .hit_vert(hv1), .new_dir(nd1), .score(score1),
    .bricks_left(bl1), .cleared(clr1), .busy(busy1)
  );

  breakout_field #(.INIT_HP(2)) u2 (
    .clk(clk), .reset(reset), .gra_still(gra_still),
    .refr_tick(refr_tick), .ball_x_l(ball_x_l), .ball_y_t(ball_y_t),
    .pix_x(pix_x), .pix_y(pix_y), .brick_on(on2), .brick_rgb(rgb2),
    .hit(hit2), .hit_vert(hv2), .new_dir(nd2), .score(score2),
    .bricks_left(bl2), .cleared(clr2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic v;
    logic d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].cyc < cyc && !hit1) begin
      chk("hit_missing_cyc", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (hit1) begin
      if (q.size() == 0) begin
        chk("unexpected_hit", 32'(hit1), 32'd0);
      end else begin
        e = q.pop_front();
        chk("hit_cyc", cyc, e.cyc);
        chk("hit_vert", 32'(hv1), 32'(e.v));
        chk("new_dir", 32'(nd1), 32'(e.d));
      end
    end
  endtask

  task automatic tick(input int x, input int y);
    ball_x_l  = 10'(x);
    ball_y_t  = 10'(y);
    refr_tick = 1'b1;
    step();
    refr_tick = 1'b0;
  endtask

  task automatic expect_hit(input int k, input logic v, input logic d);
    exp_t e;
    e.cyc = cyc + 2 + k;
    e.v   = v;
    e.d   = d;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy1 && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy1), 32'd0);
  endtask

  task automatic reload();
    gra_still = 1'b1;
    step();
    gra_still = 1'b0;
  endtask

  int n;
  int any_on;

  initial begin
    reset = 1'b1; gra_still = 1'b0; refr_tick = 1'b0;
    ball_x_l = '0; ball_y_t = '0; pix_x = 10'd50; pix_y = 10'd35;
    step();
    step();
    chk("rst_bl", 32'(bl1), 32'd0);
    chk("rst_cleared", 32'(clr1), 32'd1);
    chk("rst_score", 32'(score1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_hit", 32'(hit1), 32'd0);
    chk("rst_on", 32'(on1), 32'd0);
    reset = 1'b0;
    step();

    reload();
    chk("load_bl", 32'(bl1), 32'd48);
    chk("load_cleared", 32'(clr1), 32'd0);
    chk("load_score", 32'(score1), 32'd0);
    chk("load_busy", 32'(busy1), 32'd0);
    chk("pix_on", 32'(on1), 32'd1);
    chk("pix_rgb1", 32'(rgb1), 32'hf00);
    chk("pix_rgb2", 32'(rgb2), 32'hf80);
    pix_x = 10'd74;
    #1;
    chk("mortar_col", 32'(on1), 32'd0);
    pix_x = 10'd50;

    // Top-edge hit on brick 0.
    expect_hit(0, 1'b1, 1'b0);
    tick(50, 25);
    wait_idle();
    step();
    chk("kill_bl", 32'(bl1), 32'd47);
    chk("kill_score", 32'(score1), 32'd10);
    chk("kill_on", 32'(on1), 32'd0);
    chk("hp2_score", 32'(score2), 32'd1);
    chk("hp2_bl", 32'(bl2), 32'd48);
    chk("hp2_rgb", 32'(rgb2), 32'hf00);

    tick(50, 25);
    wait_idle();
    step();
    chk("hp2_score2", 32'(score2), 32'd11);
    chk("hp2_bl2", 32'(bl2), 32'd47);
    chk("dead_score", 32'(score1), 32'd10);

    reload();
    chk("reload_score", 32'(score1), 32'd10);
    chk("reload_bl", 32'(bl1), 32'd48);

    // Left-side hit on brick 0, right-side hit on brick 7.
    expect_hit(0, 1'b0, 1'b0);
    tick(33, 35);
    wait_idle();
    expect_hit(7, 1'b0, 1'b1);
    tick(319, 35);
    wait_idle();
    expect_hit(40, 1'b1, 1'b1);
    tick(50, 135);
    wait_idle();
    step();
    chk("three_score", 32'(score1), 32'd40);
    chk("three_bl", 32'(bl1), 32'd45);

    // Corner-only contact: full scan, no hit.
    reload();
    tick(33, 23);
    n = 0;
    while (busy1 && n < 200) begin
      n++;
      step();
    end
    chk("corner_busy", n, 48);

    // Ticks while busy are ignored.
    tick(0, 0);
    n = 0;
    while (busy1 && n < 200) begin
      n++;
      refr_tick = (n == 5 || n == 20);
      step();
    end
    refr_tick = 1'b0;
    chk("retick_busy", n, 48);
    step();
    chk("retick_idle", 32'(busy1), 32'd0);

    // Reload mid-scan aborts the pending hit on brick 40.
    tick(50, 135);
    repeat (9) step();
    reload();
    chk("abort_busy", 32'(busy1), 32'd0);
    repeat (40) step();
    chk("abort_score", 32'(score1), 32'd40);

    // Reset mid-scan aborts too.
    tick(50, 135);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_score", 32'(score1), 32'd0);
    reset = 1'b0;
    repeat (40) step();

    // Clear the whole field.
    reload();
    for (int k = 0; k < 48; k++) begin
      expect_hit(k, 1'b1, 1'b1);
      tick(40 + (k % 8) * 35 + 10, 30 + (k / 8) * 20 + 5);
      wait_idle();
    end
    step();
    chk("clear_bl", 32'(bl1), 32'd0);
    chk("clear_cleared", 32'(clr1), 32'd1);
    chk("clear_score", 32'(score1), 32'd480);
    any_on = 0;
    for (int y = 0; y < 200; y += 2) begin
      for (int x = 0; x < 400; x += 2) begin
        pix_x = 10'(x);
        pix_y = 10'(y);
        #1;
        if (on1) any_on++;
      end
    end
    chk("clear_no_pixels", any_on, 0);
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/breakout_field.md
BREAKOUT_FIELD -- requirements
Module: breakout_field

Interface
REQ-001 Parameter ROWS, default 6, brick rows.
REQ-002 Parameter COLS, default 8, brick columns; N = ROWS*COLS.
REQ-003 Parameters BRICK_W 35 / BRICK_H 20, cell size in pixels.
REQ-004 Parameters REGION_X_L 40 / REGION_Y_T 30, field top-left pixel.
REQ-005 Parameter BALL_SIZE, default 8, ball square edge.
REQ-006 Parameter HP_W 2 / INIT_HP 1, hit-point counter width and reload value per brick (1..2^HP_W-1).
REQ-007 Parameter PTS_KILL, default 10, points per destroyed brick.
REQ-008 clk  in  1  single system clock, rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 gra_still  in  1  level; reload field.
REQ-011 refr_tick  in  1  one-cycle frame tick.
REQ-012 ball_x_l, ball_y_t  in  10 each  ball top-left.
REQ-013 pix_x, pix_y  in  10 each  current pixel.
REQ-014 brick_on  out  1  pixel is on a live brick.
REQ-015 brick_rgb  out  12  brick colour at pixel.
REQ-016 hit  out  1  one-cycle collision pulse.
REQ-017 hit_vert  out  1  with hit: 1 = flip y, 0 = flip x.
REQ-018 new_dir  out  1  with hit: required sign of flipped axis, 1 = positive.
REQ-019 score  out  16  accumulated points.
REQ-020 bricks_left  out  clog2(N+1)  live brick count.
REQ-021 cleared, busy  out  1 each  bricks_left==0; state!=IDLE.

Function
REQ-022 Brick k: col = k%COLS, row = k/COLS; left = REGION_X_L+col*BRICK_W, right = left+BRICK_W-1, top = REGION_Y_T+row*BRICK_H, bottom = top+BRICK_H-1.
REQ-023 Per-brick HP_W-bit hp register; brick live iff hp != 0.
REQ-024 FSM states IDLE, SCAN, RESOLVE; one brick examined per SCAN cycle.
REQ-025 IDLE + refr_tick: latch ball_x_l/ball_y_t, idx := 0, go SCAN; refr_tick outside IDLE ignored.
REQ-026 SCAN: ball_x_r = x_l+BALL_SIZE-1, ball_y_b = y_t+BALL_SIZE-1 (latched values); overlap = live && left<=x_r && x_l<=right && top<=y_b && y_t<=bottom.
REQ-027 SCAN, overlap and left<x_r && x_l<right: go RESOLVE, hit_vert=1, new_dir = (y_t<top)?0:1.
REQ-028 SCAN, overlap, else top<y_b && y_t<bottom: go RESOLVE, hit_vert=0, new_dir = (x_l<left)?0:1.
REQ-029 Corner-only overlap (neither condition): no hit, continue scan.
REQ-030 SCAN without hit: idx==N-1 -> IDLE, else idx+1; at most one hit per frame (lowest index wins).
REQ-031 RESOLVE (one cycle): hit=1 with hit_vert/new_dir; hp[idx] -= 1; if hp becomes 0, bricks_left -= 1 and score += PTS_KILL, else score += 1; then IDLE.
REQ-032 Score saturates at 16'hFFFF.
REQ-033 Latency: brick k hit pulses in cycle k+2 after the refr_tick cycle; no-hit scan busy exactly N cycles.
REQ-034 gra_still (any state, priority over scan): all hp := INIT_HP, bricks_left := N, state := IDLE, hit = 0, score held.
REQ-035 Render combinational: brick_on = pixel within cell k, k live, and pixel not on cell's last column or last row (1-px mortar).
REQ-036 brick_rgb: hp==1 12'hf00, hp==2 12'hf80, hp>=3 12'h888; 12'h000 when brick_on=0.
REQ-037 Render uses current hp registers; updates visible from cycle after RESOLVE.

Reset
REQ-038 reset: state IDLE, idx 0, all hp 0, bricks_left 0, cleared 1, score 0, hit/hit_vert/new_dir/busy 0.
REQ-039 reset has priority over gra_still and refr_tick; reset mid-scan aborts with no hit.

Verification
REQ-040 reset, then gra_still 1 cycle -> bricks_left 48, cleared 0, score 0, busy 0.
REQ-041 ball (50,25), refr_tick at T -> hit, hit_vert 1, new_dir 0 at T+2; bricks_left 47, score 10; pixel (50,35) brick_on 0 afterward.
REQ-042 INIT_HP=2, same stimulus -> score 1, bricks_left 48, pixel (50,35) brick_rgb f80->f00; second tick -> score 11, bricks_left 47.
REQ-043 ball (33,23) corner-only on brick 0 -> no hit, busy high exactly 48 cycles.
REQ-044 refr_tick repeated while busy -> ignored; gra_still mid-scan -> IDLE next cycle, no hit, score held.
REQ-045 destroy all 48 bricks sequentially -> cleared 1 after final RESOLVE, score 480, brick_on 0 everywhere.
